// File: rtl/qed_reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qed_rf_pkg
//  Purpose  : Shared types, constants and helpers for the SQED-aware register
//             file: ceiling-log2 helper, scan FSM state encoding and the
//             derived index width / half-split point of the default build.
//  Revision : 1.0  initial release
// ============================================================================
package qed_rf_pkg;

    // Ceiling log2, usable in constant expressions (localparam widths).
    function automatic int unsigned qed_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Default geometry; modules derive their own values from NREGS.
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW        = qed_log2(NREGS_DEF);
    localparam int unsigned SPLIT     = NREGS_DEF / 2;

    // Scan FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/qed_reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : qed_reg_file_if
//  Purpose  : Bus bundle between the decoder/writeback stage (master) and the
//             register file (slave).
//  Signals  : wr_en/wr_idx/wr_data       write port
//             rd_idx/rd_data             NRP packed read ports
//             qed_commit_vld             write is a committed instruction
//             num_orig/num_dup/qed_ready commit counters and ready flag
//             scan_busy/scan_done/scan_fail/fail_idx  scan status
//  Revision : 1.0  initial release
// ============================================================================
interface qed_reg_file_if
    import qed_rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    parameter int CNT_W = 16
);
    localparam int c_AW = int'(qed_log2(NREGS));

    logic                   wr_en;
    logic [c_AW-1:0]        wr_idx;
    logic [XLEN-1:0]        wr_data;
    logic [NRP*c_AW-1:0]    rd_idx;
    logic [NRP*XLEN-1:0]    rd_data;
    logic                   qed_commit_vld;
    logic [CNT_W-1:0]       num_orig;
    logic [CNT_W-1:0]       num_dup;
    logic                   qed_ready;
    logic                   scan_busy;
    logic                   scan_done;
    logic                   scan_fail;
    logic [c_AW-1:0]        fail_idx;

    modport master (
        output wr_en, wr_idx, wr_data, rd_idx, qed_commit_vld,
        input  rd_data, num_orig, num_dup, qed_ready,
               scan_busy, scan_done, scan_fail, fail_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, rd_idx, qed_commit_vld,
        output rd_data, num_orig, num_dup, qed_ready,
               scan_busy, scan_done, scan_fail, fail_idx
    );

endinterface
`default_nettype wire

// File: rtl/qed_reg_file_commit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : qed_commit_counter
//  Purpose  : Saturating counters of committed writes to the original and
//             duplicate register halves, plus the ready flag and its
//             one-cycle-delayed copy used for scan edge detection.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             i_inc_orig/i_inc_dup  one-hot increment requests
//             o_num_orig/o_num_dup  counter values
//             o_qed_ready         counts equal and non-zero (combinational)
//             o_qed_ready_q       o_qed_ready registered
//  Revision : 1.0  initial release
// ============================================================================
module qed_commit_counter
    import qed_rf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc_orig,
    input  wire logic             i_inc_dup,
    output logic [CNT_W-1:0]      o_num_orig,
    output logic [CNT_W-1:0]      o_num_dup,
    output logic                  o_qed_ready,
    output logic                  o_qed_ready_q
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_num_orig;
    logic [CNT_W-1:0] r_num_dup;
    logic             r_ready_q;
    logic             w_ready;

    assign w_ready = (r_num_orig == r_num_dup) && (r_num_orig != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_orig <= '0;
            r_num_dup  <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            // Counters stick at all-ones rather than wrapping, so a runaway
            // half can never alias back into an "equal" state.
            if (i_inc_orig && (r_num_orig != c_MAX)) begin
                r_num_orig <= r_num_orig + CNT_W'(1);
            end
            if (i_inc_dup && (r_num_dup != c_MAX)) begin
                r_num_dup <= r_num_dup + CNT_W'(1);
            end
            r_ready_q <= w_ready;
        end
    end

    assign o_num_orig    = r_num_orig;
    assign o_num_dup     = r_num_dup;
    assign o_qed_ready   = w_ready;
    assign o_qed_ready_q = r_ready_q;

endmodule
`default_nettype wire

// File: rtl/qed_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : qed_reg_file
//  Purpose  : SQED-aware architectural register file. Single write port,
//             NRP registered read ports, index 0 hard-wired to zero. Counts
//             committed writes per half and, on the rising edge of
//             qed_ready, scans every original/duplicate pair (1..SPLIT-1),
//             one pair per cycle, latching the first mismatching index.
//  Ports    : clk, rst  clock, synchronous active-high reset
//             bus       qed_reg_file_if.slave (write, read, commit, status)
//  Config   : REGFILE_BYPASS_EN  when defined, a read of the index being
//             written in the same cycle returns the new data; otherwise the
//             old contents. Scan compares are never forwarded.
//  Revision : 1.0  initial release
// ============================================================================
module qed_reg_file
    import qed_rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    parameter int CNT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    qed_reg_file_if.slave   bus
);

    localparam int c_AW    = int'(qed_log2(NREGS));
    localparam int c_SPLIT = NREGS / 2;
    localparam logic [c_AW-1:0] c_SPLIT_IDX = c_AW'(c_SPLIT);
    localparam logic [c_AW-1:0] c_LAST_PTR  = c_AW'(c_SPLIT - 1);

    // ------------------------------------------------------------------
    // Storage and write port
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_hit;
    logic            w_commit;

    assign w_wr_hit = bus.wr_en && (bus.wr_idx != '0);
    assign w_commit = w_wr_hit && bus.qed_commit_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_regs[bus.wr_idx] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_rd_idx [NRP];
    logic [XLEN-1:0] r_rd     [NRP];

    generate
        for (genvar p = 0; p < NRP; p++) begin : g_rd
            assign w_rd_idx[p]                   = bus.rd_idx[p*c_AW +: c_AW];
            assign bus.rd_data[p*XLEN +: XLEN]   = r_rd[p];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NRP; p++) begin
                r_rd[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NRP; p++) begin
                if (w_rd_idx[p] == '0) begin
                    r_rd[p] <= '0;
`ifdef REGFILE_BYPASS_EN
                end else if (w_wr_hit && (bus.wr_idx == w_rd_idx[p])) begin
                    r_rd[p] <= bus.wr_data;
`endif
                end else begin
                    r_rd[p] <= r_regs[w_rd_idx[p]];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_num_orig;
    logic [CNT_W-1:0] w_num_dup;
    logic             w_qed_ready;
    logic             w_qed_ready_q;
    logic             w_inc_orig;
    logic             w_inc_dup;

    // NREGS is a power of two, so the index MSB selects the half.
    assign w_inc_orig = w_commit && !bus.wr_idx[c_AW-1];
    assign w_inc_dup  = w_commit &&  bus.wr_idx[c_AW-1];

    qed_commit_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .i_inc_orig    (w_inc_orig),
        .i_inc_dup     (w_inc_dup),
        .o_num_orig    (w_num_orig),
        .o_num_dup     (w_num_dup),
        .o_qed_ready   (w_qed_ready),
        .o_qed_ready_q (w_qed_ready_q)
    );

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    scan_state_t     r_state;
    logic [c_AW-1:0] r_ptr;
    logic            r_scan_busy;
    logic            r_scan_done;
    logic            r_scan_fail;
    logic [c_AW-1:0] r_fail_idx;
    logic            w_trig;
    logic            w_mismatch;

    assign w_trig = w_qed_ready && !w_qed_ready_q;

    // Reads the array directly (pre-edge contents): a write landing on the
    // pair under comparison this cycle is deliberately not seen.
    assign w_mismatch = (r_regs[r_ptr] != r_regs[r_ptr | c_SPLIT_IDX]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_scan_busy <= 1'b0;
            r_scan_done <= 1'b0;
            r_scan_fail <= 1'b0;
            r_fail_idx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_scan_done <= 1'b0;
                    if (w_trig) begin
                        r_state     <= SCAN;
                        r_ptr       <= c_AW'(1);
                        r_scan_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    // Only the first mismatch since reset is recorded.
                    if (w_mismatch && !r_scan_fail) begin
                        r_scan_fail <= 1'b1;
                        r_fail_idx  <= r_ptr;
                    end
                    if (r_ptr == c_LAST_PTR) begin
                        r_state     <= DONE;
                        r_scan_busy <= 1'b0;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + c_AW'(1);
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_scan_done <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_scan_busy <= 1'b0;
                    r_scan_done <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.num_orig  = w_num_orig;
    assign bus.num_dup   = w_num_dup;
    assign bus.qed_ready = w_qed_ready;
    assign bus.scan_busy = r_scan_busy;
    assign bus.scan_done = r_scan_done;
    assign bus.scan_fail = r_scan_fail;
    assign bus.fail_idx  = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_qed_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qed_reg_file
//  Purpose  : Directed self-checking bench for qed_reg_file (32 regs, two
//             read ports, 4-bit commit counters so saturation is reachable).
//  Revision : 1.0  initial release
// ============================================================================
module tb_qed_reg_file;
    import qed_rf_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = int'(NREGS_DEF);
    localparam int NRP   = 2;
    localparam int CNT_W = 4;
    localparam int TAW   = int'(AW);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    qed_reg_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .CNT_W(CNT_W)) bus ();

    qed_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.wr_en          = 1'b0;
        bus.wr_idx         = '0;
        bus.wr_data        = '0;
        bus.rd_idx         = '0;
        bus.qed_commit_vld = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [TAW-1:0] idx, input logic [XLEN-1:0] d, input logic c);
        bus.wr_en          = 1'b1;
        bus.wr_idx         = idx;
        bus.wr_data        = d;
        bus.qed_commit_vld = c;
        tick();
        bus.wr_en          = 1'b0;
        bus.qed_commit_vld = 1'b0;
    endtask

    // Samples 20 cycles; scan_done position is the sample number it appeared on.
    task automatic observe_scan(output int busy_cnt, output int done_cnt, output int done_at);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.scan_busy) busy_cnt++;
            if (bus.scan_done) begin
                done_cnt++;
                done_at = i;
            end
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        checks++; if (bus.num_orig !== '0) begin errors++; $display("FAIL reset_num_orig got %0d want 0", bus.num_orig); end
        checks++; if (bus.num_dup !== '0) begin errors++; $display("FAIL reset_num_dup got %0d want 0", bus.num_dup); end
        checks++; if (bus.qed_ready !== 1'b0) begin errors++; $display("FAIL reset_qed_ready got %b want 0", bus.qed_ready); end
        checks++; if ({bus.scan_busy, bus.scan_done, bus.scan_fail} !== 3'b000) begin errors++; $display("FAIL reset_scan_flags got %b want 000", {bus.scan_busy, bus.scan_done, bus.scan_fail}); end
        checks++; if (bus.fail_idx !== '0) begin errors++; $display("FAIL reset_fail_idx got %0d want 0", bus.fail_idx); end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        do_reset();
        wr(5'd5, 32'hDEADBEEF, 1'b0);
        bus.rd_idx = {5'd0, 5'd5};
        tick();
        checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_x5 got %h want deadbeef", bus.rd_data[31:0]); end
        wr(5'd0, 32'h00001234, 1'b0);
        bus.rd_idx = {5'd5, 5'd0};
        tick();
        checks++; if (bus.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL rd_x0 got %h want 0", bus.rd_data[31:0]); end
        checks++; if (bus.rd_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_port1_x5 got %h want deadbeef", bus.rd_data[63:32]); end
        checks++; if (bus.num_orig !== 4'd0) begin errors++; $display("FAIL uncommitted_no_count got %0d want 0", bus.num_orig); end
    endtask

    task automatic test_read_during_write;
        logic [31:0] exp_rdw;
`ifdef REGFILE_BYPASS_EN
        exp_rdw = 32'h22222222;
`else
        exp_rdw = 32'h11111111;
`endif
        do_reset();
        wr(5'd7, 32'h11111111, 1'b0);
        bus.rd_idx  = {5'd0, 5'd7};
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 5'd7;
        bus.wr_data = 32'h22222222;
        tick();
        bus.wr_en = 1'b0;
        checks++; if (bus.rd_data[31:0] !== exp_rdw) begin errors++; $display("FAIL rdw_x7 got %h want %h", bus.rd_data[31:0], exp_rdw); end
        tick();
        checks++; if (bus.rd_data[31:0] !== 32'h22222222) begin errors++; $display("FAIL rdw_after got %h want 22222222", bus.rd_data[31:0]); end
    endtask

    task automatic test_scan_pass;
        int b, d, at;
        do_reset();
        wr(5'd1, 32'd3, 1'b1);
        wr(5'd17, 32'd3, 1'b1);
        checks++; if ({bus.num_orig, bus.num_dup} !== {4'd1, 4'd1}) begin errors++; $display("FAIL pass_counts got %0d/%0d want 1/1", bus.num_orig, bus.num_dup); end
        checks++; if (bus.qed_ready !== 1'b1) begin errors++; $display("FAIL pass_ready got %b want 1", bus.qed_ready); end
        observe_scan(b, d, at);
        checks++; if (b != 15) begin errors++; $display("FAIL pass_busy_cycles got %0d want 15", b); end
        checks++; if (d != 1 || at != 16) begin errors++; $display("FAIL pass_done got %0d pulses at %0d want 1 at 16", d, at); end
        checks++; if (bus.scan_fail !== 1'b0) begin errors++; $display("FAIL pass_scan_fail got %b want 0", bus.scan_fail); end
    endtask

    task automatic test_scan_fail;
        int b, d, at;
        do_reset();
        wr(5'd3, 32'd6, 1'b0);
        wr(5'd19, 32'd7, 1'b0);
        wr(5'd2, 32'd4, 1'b1);
        wr(5'd18, 32'd5, 1'b1);
        observe_scan(b, d, at);
        checks++; if (d != 1) begin errors++; $display("FAIL fail_done got %0d pulses want 1", d); end
        checks++; if (bus.scan_fail !== 1'b1) begin errors++; $display("FAIL fail_flag got %b want 1", bus.scan_fail); end
        checks++; if (bus.fail_idx !== 5'd2) begin errors++; $display("FAIL fail_idx got %0d want 2", bus.fail_idx); end
        // Repair pair 2, leave pair 3 mismatched, and retrigger.
        wr(5'd2, 32'd5, 1'b0);
        wr(5'd3, 32'd8, 1'b1);
        checks++; if (bus.qed_ready !== 1'b0) begin errors++; $display("FAIL fail_ready_drop got %b want 0", bus.qed_ready); end
        wr(5'd19, 32'd9, 1'b1);
        observe_scan(b, d, at);
        checks++; if (d != 1) begin errors++; $display("FAIL rescan_done got %0d pulses want 1", d); end
        checks++; if (bus.scan_fail !== 1'b1 || bus.fail_idx !== 5'd2) begin errors++; $display("FAIL sticky_fail_idx got %b/%0d want 1/2", bus.scan_fail, bus.fail_idx); end
    endtask

    task automatic test_reset_mid_scan;
        int b, d, at;
        do_reset();
        wr(5'd4, 32'hA5A5A5A5, 1'b0);
        wr(5'd1, 32'd1, 1'b1);
        wr(5'd17, 32'd2, 1'b1);
        repeat (5) tick();
        checks++; if (bus.scan_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.scan_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.scan_busy, bus.scan_done, bus.scan_fail, bus.qed_ready} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags got %b want 0000", {bus.scan_busy, bus.scan_done, bus.scan_fail, bus.qed_ready}); end
        checks++; if ({bus.num_orig, bus.num_dup, bus.fail_idx} !== '0) begin errors++; $display("FAIL mid_rst_counts got %0d/%0d/%0d want 0/0/0", bus.num_orig, bus.num_dup, bus.fail_idx); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL mid_rst_rd_data got %h want 0", bus.rd_data); end
        bus.rd_idx = {5'd1, 5'd4};
        observe_scan(b, d, at);
        checks++; if (b != 0 || d != 0) begin errors++; $display("FAIL mid_no_scan got busy %0d done %0d want 0/0", b, d); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL mid_array_cleared got %h want 0", bus.rd_data); end
    endtask

    task automatic test_saturation;
        do_reset();
        wr(5'd0, 32'd9, 1'b1);
        checks++; if ({bus.num_orig, bus.num_dup} !== 8'h00) begin errors++; $display("FAIL x0_commit got %0d/%0d want 0/0", bus.num_orig, bus.num_dup); end
        wr(5'd15, 32'd1, 1'b1);
        checks++; if ({bus.num_orig, bus.num_dup} !== {4'd1, 4'd0}) begin errors++; $display("FAIL x15_orig got %0d/%0d want 1/0", bus.num_orig, bus.num_dup); end
        wr(5'd16, 32'd1, 1'b1);
        checks++; if ({bus.num_orig, bus.num_dup, bus.qed_ready} !== {4'd1, 4'd1, 1'b1}) begin errors++; $display("FAIL x16_dup got %0d/%0d rdy %b want 1/1/1", bus.num_orig, bus.num_dup, bus.qed_ready); end
        for (int i = 0; i < 16; i++) wr(5'd1, 32'(i), 1'b1);
        checks++; if (bus.num_orig !== 4'd15) begin errors++; $display("FAIL orig_saturate got %0d want 15", bus.num_orig); end
        checks++; if (bus.qed_ready !== 1'b0) begin errors++; $display("FAIL sat_ready got %b want 0", bus.qed_ready); end
        wr(5'd2, 32'd1, 1'b0);
        wr(5'd20, 32'd1, 1'b0);
        checks++; if ({bus.num_orig, bus.num_dup} !== {4'd15, 4'd1}) begin errors++; $display("FAIL no_commit_hold got %0d/%0d want 15/1", bus.num_orig, bus.num_dup); end
        for (int i = 0; i < 20; i++) wr(5'd31, 32'(i), 1'b1);
        checks++; if ({bus.num_dup, bus.qed_ready} !== {4'd15, 1'b1}) begin errors++; $display("FAIL dup_saturate got %0d rdy %b want 15/1", bus.num_dup, bus.qed_ready); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_scan_pass();
        test_scan_fail();
        test_reset_mid_scan();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qed_reg_file.md
Name: qed_reg_file

Overview:
Parametrised SQED-aware register file, successor to the single-write, dual-read 32x32 file.
- Configurable data width, depth and read-port count; index 0 reads as zero.
- Counts committed writes to the original half (indices 1..SPLIT-1) and the duplicate half (SPLIT..NREGS-1).
- When the counts match, a scan FSM compares each original/duplicate register pair, one pair per cycle, and flags any mismatch.
- Sits between the instruction decoder/writeback and the ALU, as the core's architectural register file under SQED verification.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, register count; power of 2, >=4
NRP, 2, number of read ports, 1..4
CNT_W, 16, commit counter width
(derived, package) AW = log2(NREGS); SPLIT = NREGS/2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  write enable
wr_idx  in  AW  write index
wr_data  in  XLEN  write data
rd_idx  in  NRP*AW  read indices, port p at bits [p*AW +: AW]
rd_data  out  NRP*XLEN  registered read data, port p at bits [p*XLEN +: XLEN]
qed_commit_vld  in  1  the current write is a committed instruction
num_orig  out  CNT_W  committed writes to the original half
num_dup  out  CNT_W  committed writes to the duplicate half
qed_ready  out  1  num_orig==num_dup and num_orig!=0 (combinational from counters)
scan_busy  out  1  scan FSM is in SCAN
scan_done  out  1  one-cycle pulse when a scan completes
scan_fail  out  1  sticky mismatch flag, cleared only by rst
fail_idx  out  AW  original-half index of the first mismatch

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - every array entry;
  - rd_data, num_orig, num_dup, scan_busy, scan_done, scan_fail, fail_idx.
  - The FSM returns to IDLE. This holds mid-scan: the scan is aborted and no scan_done pulse is issued.
- Write: when wr_en=1 and wr_idx!=0, the array entry is updated at the clk edge. Writes to index 0 are dropped.
- Read:
  - 1-cycle latency: rd_data[p] = array[rd_idx[p]] sampled at the edge.
  - rd_idx=0 returns 0.
  - Read-during-write to the same index returns the old value (see REGFILE_BYPASS_EN).
- Commit counting applies when wr_en && qed_commit_vld && wr_idx!=0:
  - wr_idx<SPLIT increments num_orig;
  - otherwise num_dup is incremented.
  - Both counters saturate at all-ones and never wrap.
- Scan start: trig = qed_ready && !qed_ready_q, where qed_ready_q is qed_ready registered. A trig while in SCAN or DONE is ignored.
- FSM:
  - IDLE: on trig go to SCAN with ptr=1.
  - SCAN:
    - Compare array[ptr] with array[ptr+SPLIT] using pre-edge contents; a write landing on the compared pair in the same cycle is not seen.
    - On the first mismatch while scan_fail=0, set scan_fail=1 and fail_idx=ptr. Later mismatches do not change fail_idx.
    - If ptr==SPLIT-1, go to DONE; otherwise ptr+1.
  - DONE: scan_done=1 for exactly this cycle, then go to IDLE.
  - Pair 0 is never compared.
- Scan length is SPLIT-1 cycles in SCAN, plus 1 in DONE.
- scan_busy=1 only in SCAN.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: same-cycle write-to-read forwarding. If wr_en && wr_idx!=0 && wr_idx==rd_idx[p], rd_data[p] gets wr_data at that edge.
- Undefined: the old value is returned.
- Scan compares are never bypassed in either build.

Decomposition:
- Package qed_rf_pkg holds:
  - the log2 helper function;
  - the FSM state enum: IDLE, SCAN, DONE;
  - localparams for AW and SPLIT.
- One sub-module, qed_commit_counter, holds the two saturating counters and qed_ready/qed_ready_q.
- The array, read ports and scan FSM stay in qed_reg_file.

Test Plan:
- Write x5=0xDEADBEEF; next cycle rd_idx0=5 -> rd_data0=0xDEADBEEF one cycle later. Write x0=0x1234 -> reading x0 gives 0.
- Read and write x7 in the same cycle:
  - old value expected without REGFILE_BYPASS_EN;
  - new value with it defined.
- Commit writes x1=3, x17=3 (qed_commit_vld=1) -> num_orig=1, num_dup=1, qed_ready=1. Scan runs 15 cycles, then scan_done pulses; scan_fail=0.
- Commit x2=4, x18=5 -> after the scan, scan_fail=1, fail_idx=2. A later mismatch at x3/x19 leaves fail_idx=2.
- Assert rst in the 5th SCAN cycle -> next cycle all outputs are 0, FSM is IDLE, and no scan_done pulse is issued.
- Force num_orig near all-ones via commits with CNT_W=4 -> counter holds at 15; wr_en with qed_commit_vld=0 -> counters unchanged.
